// File: rtl/MD_pkg.sv
// Shared widths and types for the MD cell datapath, plus the velocity-cell
// access controller state and response-tag types.
package MD_pkg;

    localparam int unsigned FLOAT_STRUCT_WIDTH   = 32;
    localparam int unsigned PARTICLE_ID_WIDTH    = 8;
    localparam int unsigned VEL_CACHE_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        SERVE,
        DUMP,
        DRAIN
    } vcell_ctrl_state_t;

    typedef enum logic {
        SrcClient,
        SrcDump
    } vcell_rsp_src_t;

    typedef struct packed {
        logic                         valid;
        vcell_rsp_src_t               src;
        logic [PARTICLE_ID_WIDTH-1:0] addr;
    } vcell_rsp_tag_t;

endpackage

// File: rtl/vcell_rsp_pipe.sv
// Delay line for read tags, kept in step with the cache read latency so the
// tail lines up with cache_vel_out.
module vcell_rsp_pipe
    import MD_pkg::*;
#(
    parameter int unsigned Depth = VEL_CACHE_RD_LATENCY
) (
    input  logic           clk,
    input  logic           rst_n,
    input  vcell_rsp_tag_t tag_i,
    output vcell_rsp_tag_t tag_o
);

    vcell_rsp_tag_t tag_q [Depth];
    vcell_rsp_tag_t tag_d [Depth];

    always_comb begin
        tag_d[0] = tag_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < Depth; i++) begin
            if (!rst_n) begin
                tag_q[i] <= '0;
            end else begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign tag_o = tag_q[Depth-1];

endmodule

// File: rtl/vcell_access_ctrl.sv
// Arbitrates the motion-update write stream and the client read stream onto one
// velocity cache cell, and streams a frozen snapshot of every velocity on demand.
module vcell_access_ctrl
    import MD_pkg::*;
#(
    parameter int unsigned NUM_PARTICLES = 64,
    parameter int unsigned RD_LATENCY    = VEL_CACHE_RD_LATENCY
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [PARTICLE_ID_WIDTH-1:0]  wr_addr,
    input  logic [FLOAT_STRUCT_WIDTH-1:0] wr_vel,
    input  logic                          rd_valid,
    output logic                          rd_ready,
    input  logic [PARTICLE_ID_WIDTH-1:0]  rd_addr,
    output logic                          rsp_valid,
    output logic [PARTICLE_ID_WIDTH-1:0]  rsp_addr,
    output logic [FLOAT_STRUCT_WIDTH-1:0] rsp_vel,
    input  logic                          dump_start,
    output logic                          dump_busy,
    output logic                          dump_valid,
    output logic [PARTICLE_ID_WIDTH-1:0]  dump_addr,
    output logic [FLOAT_STRUCT_WIDTH-1:0] dump_vel,
    output logic                          dump_done,
    output logic                          cache_wr_en,
    output logic [PARTICLE_ID_WIDTH-1:0]  cache_wr_addr,
    output logic [FLOAT_STRUCT_WIDTH-1:0] cache_vel_in,
    output logic [PARTICLE_ID_WIDTH-1:0]  cache_rd_addr,
    input  logic [FLOAT_STRUCT_WIDTH-1:0] cache_vel_out
);

    localparam int unsigned IdW    = PARTICLE_ID_WIDTH;
    localparam int unsigned DrainW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [IdW-1:0]    LastId    = IdW'(NUM_PARTICLES - 1);
    localparam logic [DrainW-1:0] LastDrain = DrainW'(RD_LATENCY - 1);

    if (RD_LATENCY < 1) begin : g_bad_latency
        $error("RD_LATENCY must be at least 1");
    end
    if (NUM_PARTICLES < 1 || NUM_PARTICLES > (1 << IdW)) begin : g_bad_count
        $error("NUM_PARTICLES must fit in PARTICLE_ID_WIDTH");
    end

    vcell_ctrl_state_t state_q, state_d;
    logic [IdW-1:0]    dump_cnt_q, dump_cnt_d;
    logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;

    logic serving, dumping, draining, collide, wr_fire, rd_fire;
    vcell_rsp_tag_t pipe_in, pipe_out;
    logic tail_valid;

    // Outputs are qualified with rst_n so every output is 0 while reset is held.
    assign serving  = rst_n && (state_q == SERVE);
    assign dumping  = rst_n && (state_q == DUMP);
    assign draining = rst_n && (state_q == DRAIN);

    // Same-ID write and read: let the write land first, read retries next cycle.
    assign collide  = wr_valid && rd_valid && (wr_addr == rd_addr);
    assign wr_ready = serving;
    assign rd_ready = serving && !collide;
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;

    assign cache_wr_en   = wr_fire;
    assign cache_wr_addr = wr_fire ? wr_addr : '0;
    assign cache_vel_in  = wr_fire ? wr_vel : '0;

    always_comb begin
        cache_rd_addr = '0;
        if (rd_fire) begin
            cache_rd_addr = rd_addr;
        end else if (dumping) begin
            cache_rd_addr = dump_cnt_q;
        end
    end

    always_comb begin
        pipe_in       = '0;
        pipe_in.valid = rd_fire || dumping;
        pipe_in.src   = dumping ? SrcDump : SrcClient;
        pipe_in.addr  = cache_rd_addr;
    end

    vcell_rsp_pipe #(
        .Depth (RD_LATENCY)
    ) u_rsp_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (pipe_in),
        .tag_o (pipe_out)
    );

    assign tail_valid = rst_n && pipe_out.valid;
    assign rsp_valid  = tail_valid && (pipe_out.src == SrcClient);
    assign dump_valid = tail_valid && (pipe_out.src == SrcDump);
    assign rsp_addr   = rsp_valid ? pipe_out.addr : '0;
    assign rsp_vel    = rsp_valid ? cache_vel_out : '0;
    assign dump_addr  = dump_valid ? pipe_out.addr : '0;
    assign dump_vel   = dump_valid ? cache_vel_out : '0;

    assign dump_busy = dumping || draining;
    assign dump_done = draining && (drain_cnt_q == LastDrain);

    always_comb begin
        state_d     = state_q;
        dump_cnt_d  = dump_cnt_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            SERVE: begin
                if (dump_start) begin
                    state_d    = DUMP;
                    dump_cnt_d = '0;
                end
            end
            DUMP: begin
                if (dump_cnt_q == LastId) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    dump_cnt_d = dump_cnt_q + IdW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt_q == LastDrain) begin
                    state_d = SERVE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DrainW'(1);
                end
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SERVE;
            dump_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dump_cnt_q  <= dump_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

endmodule

// File: tb/tb_vcell_access_ctrl.sv
// Randomised bench for vcell_access_ctrl: a cache model drives cache_vel_out and a
// transaction-level reference predicts every handshake, response and dump beat.
module tb_vcell_access_ctrl;
    import MD_pkg::*;

    localparam int N  = 64;
    localparam int L  = 2;
    localparam int DW = FLOAT_STRUCT_WIDTH;
    localparam int AW = PARTICLE_ID_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0, rd_valid = 1'b0, dump_start = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_vel = '0;
    logic          wr_ready, rd_ready, rsp_valid, dump_busy, dump_valid, dump_done;
    logic [AW-1:0] rsp_addr, dump_addr, cache_wr_addr, cache_rd_addr;
    logic [DW-1:0] rsp_vel, dump_vel, cache_vel_in, cache_vel_out;
    logic          cache_wr_en;

    vcell_access_ctrl #(
        .NUM_PARTICLES (N),
        .RD_LATENCY    (L)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_vel        (wr_vel),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rsp_valid     (rsp_valid),
        .rsp_addr      (rsp_addr),
        .rsp_vel       (rsp_vel),
        .dump_start    (dump_start),
        .dump_busy     (dump_busy),
        .dump_valid    (dump_valid),
        .dump_addr     (dump_addr),
        .dump_vel      (dump_vel),
        .dump_done     (dump_done),
        .cache_wr_en   (cache_wr_en),
        .cache_wr_addr (cache_wr_addr),
        .cache_vel_in  (cache_vel_in),
        .cache_rd_addr (cache_rd_addr),
        .cache_vel_out (cache_vel_out)
    );

    always #5 clk = ~clk;

    // Behavioural VEL_CACHE: registered write, read data L cycles after the address.
    logic [DW-1:0] mem [256] = '{default: '0};
    logic [DW-1:0] rdp [L]   = '{default: '0};
    always @(posedge clk) begin
        if (cache_wr_en) mem[cache_wr_addr] <= cache_vel_in;
        rdp[0] <= mem[cache_rd_addr];
        for (int i = 1; i < L; i++) rdp[i] <= rdp[i-1];
    end
    assign cache_vel_out = rdp[L-1];

    // Reference: shadow contents, expected beats keyed by the cycle they appear,
    // and the position within a dump (-1 when serving clients).
    typedef struct {
        int            due;
        bit            is_dump;
        int            addr;
        logic [DW-1:0] vel;
    } exp_t;

    logic [DW-1:0] refmem [256] = '{default: '0};
    exp_t expq [$];
    int   k = -1;
    int   cyc = 0;
    bit   wr_acc, rd_acc;
    int   n_checks = 0;
    int   n_fails = 0;

    bit            pw = 0, pr = 0;
    int            pwa = 0, pra = 0;
    logic [DW-1:0] pwd = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input bit rs, input bit wv, input int wa, input logic [DW-1:0] wd,
                        input bit rv, input int ra, input bit ds);
        bit   serve, ewr, erd, hit;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = rs;
        wr_valid   = wv;
        wr_addr    = AW'(wa);
        wr_vel     = wd;
        rd_valid   = rv;
        rd_addr    = AW'(ra);
        dump_start = ds;
        #1;
        hit = 0;
        e   = '{due: 0, is_dump: 0, addr: 0, vel: '0};
        if (!rs) begin
            check("rst wr_ready", wr_ready, 0);
            check("rst rd_ready", rd_ready, 0);
            check("rst cache_wr_en", cache_wr_en, 0);
            check("rst cache_addrs", {cache_wr_addr, cache_rd_addr, cache_vel_in}, 0);
            check("rst rsp", {rsp_valid, rsp_addr, rsp_vel}, 0);
            check("rst dump", {dump_valid, dump_addr, dump_vel}, 0);
            check("rst busy_done", {dump_busy, dump_done}, 0);
            expq.delete();
            k      = -1;
            wr_acc = 0;
            rd_acc = 0;
        end else begin
            serve  = (k < 0);
            ewr    = serve;
            erd    = serve && !(wv && rv && wa == ra);
            wr_acc = wv && ewr;
            rd_acc = rv && erd;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                e   = expq.pop_front();
                hit = 1;
            end
            check("wr_ready", wr_ready, ewr);
            check("rd_ready", rd_ready, erd);
            check("cache_wr_en", cache_wr_en, wr_acc);
            if (wr_acc) begin
                check("cache_wr_addr", cache_wr_addr, 64'(wa));
                check("cache_vel_in", cache_vel_in, wd);
            end
            if (rd_acc) check("cache_rd_addr rd", cache_rd_addr, 64'(ra));
            if (k >= 0 && k < N) check("cache_rd_addr dump", cache_rd_addr, 64'(k));
            check("rsp_valid", rsp_valid, hit && !e.is_dump);
            if (hit && !e.is_dump) begin
                check("rsp_addr", rsp_addr, 64'(e.addr));
                check("rsp_vel", rsp_vel, e.vel);
            end
            check("dump_valid", dump_valid, hit && e.is_dump);
            if (hit && e.is_dump) begin
                check("dump_addr", dump_addr, 64'(e.addr));
                check("dump_vel", dump_vel, e.vel);
            end
            check("dump_busy", dump_busy, !serve);
            check("dump_done", dump_done, k == N + L - 1);
            if (rd_acc) expq.push_back('{due: cyc + L, is_dump: 0, addr: ra, vel: refmem[ra]});
            if (wr_acc) refmem[wa] = wd;
            if (k >= 0 && k < N) expq.push_back('{due: cyc + L, is_dump: 1, addr: k, vel: refmem[k]});
            if (serve) begin
                if (ds) k = 0;
            end else begin
                k = (k == N + L - 1) ? -1 : k + 1;
            end
        end
        cyc++;
    endtask

    // One cycle with the pending requests held until the reference accepts them.
    task automatic tick(input bit rs, input bit ds);
        step(rs, pw, pwa, pwd, pr, pra, ds);
        if (wr_acc) pw = 0;
        if (rd_acc) pr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0);
    endtask

    initial begin
        // Reset with requests asserted, then release.
        pw = 1; pwa = 1; pwd = 32'hDEAD; pr = 1; pra = 2;
        for (int i = 0; i < 3; i++) tick(0, 0);
        pw = 0; pr = 0;
        idle(2);

        // Write then read back; preload ID 9 for the collision case.
        pw = 1; pwa = 9; pwd = 32'h11; tick(1, 0);
        pw = 1; pwa = 5; pwd = 32'hA5; tick(1, 0);
        pr = 1; pra = 5; tick(1, 0);
        idle(3);

        // Same-ID write and read in one cycle.
        pw = 1; pwa = 9; pwd = 32'h33; pr = 1; pra = 9;
        idle(5);

        // Preload value=ID and take a full dump.
        for (int i = 0; i < N; i++) begin
            pw = 1; pwa = i; pwd = DW'(i); tick(1, 0);
        end
        tick(1, 1);
        idle(N + L + 3);

        // Write held across a dump stays frozen until SERVE resumes.
        tick(1, 1);
        pw = 1; pwa = 3; pwd = 32'hFF;
        idle(N + L + 2);
        pr = 1; pra = 3;
        idle(4);

        // Reset on dump beat 20, then restart the dump from ID 0.
        tick(1, 1);
        idle(20 + L);
        tick(0, 0);
        tick(0, 0);
        idle(N + L + 4);
        tick(1, 1);
        idle(N + L + 3);

        // Randomised traffic with narrow IDs for collisions, some out-of-range IDs.
        for (int c = 0; c < 4000; c++) begin
            if (!pw && ($urandom % 2 == 0)) begin
                pw  = 1;
                pwa = ($urandom % 10 == 0) ? int'($urandom % 256) : int'($urandom % 16);
                pwd = $urandom;
            end
            if (!pr && ($urandom % 2 == 0)) begin
                pr  = 1;
                pra = ($urandom % 10 == 0) ? int'($urandom % 256) : int'($urandom % 16);
            end
            tick(($urandom % 600) != 0, ($urandom % 150) == 0);
        end
        pw = 0; pr = 0;
        idle(N + L + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
